hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter REG_AW, default 2, register-address width.
REQ-002 Parameter NUM_SRC, default 2, number of ID-stage source operands checked.
REQ-003 Parameter STORE_CYC, default 2, total stall cycles for a store request.
REQ-004 Parameter OUT_PRE, default 2, stall cycles before out_en_master rises; parameter OUT_HOLD, default 2, cycles out_en_master is held high.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 id_src_addr  in  NUM_SRC*REG_AW  ID source addresses, operand i at [i*REG_AW +: REG_AW].
REQ-008 id_src_valid  in  NUM_SRC  operand i actually read.
REQ-009 ex_dst_addr / mem_dst_addr / wb_dst_addr  in  REG_AW each  destination address per stage.
REQ-010 ex_wb_en / mem_wb_en / wb_wb_en  in  1 each  stage writes the register file.
REQ-011 ex_mem_read  in  1  EX instruction is a load.
REQ-012 br_taken  in  1  branch resolved taken in EX.
REQ-013 id_store_req / id_out_req  in  1 each  ID holds a store / output instruction.
REQ-014 pc_en, if_en, id_stall, br_clr, out_en_master  out  1 each  pipeline controls.
REQ-015 fwd_sel  out  NUM_SRC*2  per-operand bypass select: 00 regfile, 01 MEM, 10 EX, 11 WB.

Function
REQ-016 Forwarding SHALL be combinational; per operand, priority EX (ex_wb_en, not ex_mem_read, address match) -> 10, else MEM match (mem_wb_en) -> 01, else WB match (wb_wb_en) -> 11, else 00; youngest producer wins.
REQ-017 Operands with id_src_valid=0 SHALL get fwd_sel=00 and never cause stalls.
REQ-018 Load-use: ex_mem_read & ex_wb_en & valid operand matching ex_dst_addr SHALL combinationally drive pc_en=0, if_en=0, id_stall=1 for exactly that cycle; no state change.
REQ-019 FSM states IDLE, ST_STALL, OUT_PRE_S, OUT_HOLD_S; counter width $clog2(max cycle param)+1.
REQ-020 IDLE: id_out_req (no load-use) -> OUT_PRE_S; else id_store_req -> ST_STALL; out wins if both; counter cleared on entry.
REQ-021 ST_STALL SHALL stall (pc_en=0, if_en=0, id_stall=1) for STORE_CYC cycles counted from the request cycle, then IDLE with pc_en=1.
REQ-022 OUT_PRE_S stalls with out_en_master=0 for OUT_PRE cycles; OUT_HOLD_S stalls with out_en_master=1 for OUT_HOLD cycles, then IDLE.
REQ-023 In IDLE with no hazard: pc_en=1, if_en=1, id_stall=0, out_en_master=0.
REQ-024 br_clr SHALL equal br_taken combinationally (also 1 during reset).
REQ-025 br_taken in any non-IDLE state SHALL abort: next state IDLE, counter 0, out_en_master low next cycle.
REQ-026 Requests arriving during non-IDLE states SHALL be ignored; re-sampled on return to IDLE.

Reset
REQ-027 rst=0 at rising edge SHALL set state IDLE, counter 0, mid-operation included.
REQ-028 While rst=0: pc_en=0, if_en=0, id_stall=0, out_en_master=0, br_clr=1, fwd_sel=0.

Configuration
REQ-029 Macro HZ_WB_FWD_EN: defined -> WB forwarding (select 11) active; undefined -> wb_dst_addr/wb_wb_en ignored, select 11 never produced.

Structure
REQ-030 Package hazard_pkg holds fwd_sel encoding constants and FSM state typedef.
REQ-031 Sub-module hz_fwd_cmp: one-operand priority comparator, instantiated NUM_SRC times via generate.

Verification
REQ-032 ex_wb_en=1, ex_dst=2, mem_wb_en=1, mem_dst=2, src0=2 -> fwd_sel[1:0]=10 (EX wins).
REQ-033 ex_mem_read=1, ex_dst=1, src1=1 valid -> one cycle pc_en=0, id_stall=1; src1 invalid -> no stall.
REQ-034 id_out_req pulse, defaults -> 2 cycles stall out_en=0, 2 cycles stall out_en=1, then pc_en=1.
REQ-035 id_store_req in ST_STALL cycle 1 plus br_taken -> br_clr=1 same cycle, IDLE and pc_en=1 next cycle.
REQ-036 rst=0 during OUT_HOLD_S -> next edge IDLE, out_en_master=0; with HZ_WB_FWD_EN undefined, WB match -> fwd_sel=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard / forwarding unit.
// Holds fwd_sel codes and the stall FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ST_STALL   = 2'd1,
    OUT_PRE_S  = 2'd2,
    OUT_HOLD_S = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hz_fwd_cmp.sv
// One-operand bypass priority comparator and load-use detector.
// Ports: src_addr/src_valid operand; ex/mem/wb producer info;
//   sel bypass select, load_use raw hazard on a load in EX.
// HZ_WB_FWD_EN: when defined, WB producers are bypassed (sel 11).
module hz_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = 2
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_valid,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic              ex_wb_en,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] wb_dst_addr,
  input  logic              wb_wb_en,
  output logic [1:0]        sel,
  output logic              load_use
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = ex_wb_en && (src_addr == ex_dst_addr);
  assign mem_hit = mem_wb_en && (src_addr == mem_dst_addr);

`ifdef HZ_WB_FWD_EN
  assign wb_hit = wb_wb_en && (src_addr == wb_dst_addr);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_dst_addr, wb_wb_en};
  assign wb_hit    = 1'b0;
`endif

  // A load in EX has no data yet: it cannot be bypassed,
  // so an older MEM/WB match may still be chosen.
  always_comb begin
    sel = FWD_RF;
    if (src_valid) begin
      if (ex_hit && !ex_mem_read)
        sel = FWD_EX;
      else if (mem_hit)
        sel = FWD_MEM;
      else if (wb_hit)
        sel = FWD_WB;
    end
  end

  assign load_use = src_valid && ex_mem_read && ex_hit;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection, operand forwarding and store/output stall FSM.
// Ports: clk, rst (sync, active-low); ID operands; EX/MEM/WB
//   producers; br_taken, id_store_req, id_out_req in;
//   pc_en, if_en, id_stall, br_clr, out_en_master, fwd_sel out.
// HZ_WB_FWD_EN: enables WB-stage bypass (fwd_sel 11).
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 2,
  parameter int NUM_SRC   = 2,
  parameter int STORE_CYC = 2,
  parameter int OUT_PRE   = 2,
  parameter int OUT_HOLD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic [REG_AW-1:0]         ex_dst_addr,
  input  logic [REG_AW-1:0]         mem_dst_addr,
  input  logic [REG_AW-1:0]         wb_dst_addr,
  input  logic                      ex_wb_en,
  input  logic                      mem_wb_en,
  input  logic                      wb_wb_en,
  input  logic                      ex_mem_read,
  input  logic                      br_taken,
  input  logic                      id_store_req,
  input  logic                      id_out_req,
  output logic                      pc_en,
  output logic                      if_en,
  output logic                      id_stall,
  output logic                      br_clr,
  output logic                      out_en_master,
  output logic [NUM_SRC*2-1:0]      fwd_sel
);

  localparam int M1   = (STORE_CYC > OUT_PRE) ? STORE_CYC : OUT_PRE;
  localparam int MAXC = (M1 > OUT_HOLD) ? M1 : OUT_HOLD;
  localparam int CW   = $clog2(MAXC) + 1;

  logic [NUM_SRC-1:0]   lu_vec;
  logic [NUM_SRC*2-1:0] sel_raw;
  logic                 load_use;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cmp
    hz_fwd_cmp #(
      .REG_AW(REG_AW)
    ) u_cmp (
      .src_addr    (id_src_addr[i*REG_AW +: REG_AW]),
      .src_valid   (id_src_valid[i]),
      .ex_dst_addr (ex_dst_addr),
      .ex_wb_en    (ex_wb_en),
      .ex_mem_read (ex_mem_read),
      .mem_dst_addr(mem_dst_addr),
      .mem_wb_en   (mem_wb_en),
      .wb_dst_addr (wb_dst_addr),
      .wb_wb_en    (wb_wb_en),
      .sel         (sel_raw[i*2 +: 2]),
      .load_use    (lu_vec[i])
    );
  end

  assign load_use = |lu_vec;

  hz_state_e     state;
  hz_state_e     nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          fsm_stall;
  logic          fsm_out;
  logic          stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The request cycle is the first stall cycle, so each busy
  // state lasts one cycle less than its total.  Requests are
  // treated as pulses from ID; a flushed or load-blocked ID
  // instruction does not start a sequence.
  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt;
    fsm_stall = 1'b0;
    fsm_out   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!load_use && !br_taken) begin
          if (id_out_req) begin
            fsm_stall = 1'b1;
            cnt_nxt   = '0;
            nxt       = (OUT_PRE > 1) ? OUT_PRE_S : OUT_HOLD_S;
          end else if (id_store_req) begin
            fsm_stall = 1'b1;
            cnt_nxt   = '0;
            nxt       = (STORE_CYC > 1) ? ST_STALL : IDLE;
          end
        end
      end
      ST_STALL: begin
        fsm_stall = 1'b1;
        if (int'(cnt) >= STORE_CYC - 2) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      OUT_PRE_S: begin
        fsm_stall = 1'b1;
        if (int'(cnt) >= OUT_PRE - 2) begin
          nxt     = OUT_HOLD_S;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      OUT_HOLD_S: begin
        fsm_stall = 1'b1;
        fsm_out   = 1'b1;
        if (int'(cnt) >= OUT_HOLD - 1) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase
    // A taken branch flushes the stalled instruction.
    if (state != IDLE && br_taken) begin
      nxt     = IDLE;
      cnt_nxt = '0;
    end
  end

  assign stall         = fsm_stall | load_use;
  assign pc_en         = rst & ~stall;
  assign if_en         = rst & ~stall;
  assign id_stall      = rst & stall;
  assign out_en_master = rst & fsm_out;
  assign br_clr        = br_taken | ~rst;
  assign fwd_sel       = rst ? sel_raw : '0;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit.
// Directed scenarios plus randomized forwarding / FSM runs.
module tb_hazard_fwd_unit;
  import hazard_pkg::*;

  localparam int AW = 2;
  localparam int NS = 2;
  localparam int SC = 2;
  localparam int OP = 2;
  localparam int OH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS*AW-1:0] id_src_addr;
  logic [NS-1:0] id_src_valid;
  logic [AW-1:0] ex_dst_addr, mem_dst_addr, wb_dst_addr;
  logic          ex_wb_en, mem_wb_en, wb_wb_en, ex_mem_read;
  logic          br_taken, id_store_req, id_out_req;
  logic          pc_en, if_en, id_stall, br_clr, out_en_master;
  logic [NS*2-1:0] fwd_sel;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .REG_AW(AW), .NUM_SRC(NS), .STORE_CYC(SC),
    .OUT_PRE(OP), .OUT_HOLD(OH)
  ) dut (
    .clk(clk), .rst(rst),
    .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
    .ex_dst_addr(ex_dst_addr), .mem_dst_addr(mem_dst_addr),
    .wb_dst_addr(wb_dst_addr), .ex_wb_en(ex_wb_en),
    .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en),
    .ex_mem_read(ex_mem_read), .br_taken(br_taken),
    .id_store_req(id_store_req), .id_out_req(id_out_req),
    .pc_en(pc_en), .if_en(if_en), .id_stall(id_stall),
    .br_clr(br_clr), .out_en_master(out_en_master),
    .fwd_sel(fwd_sel)
  );

  // Youngest valid producer holding the address wins.
  function automatic logic [1:0] ref_sel(
    input logic [AW-1:0] a, input logic v);
    logic [AW-1:0] pa [3];
    logic          pv [3];
    logic [1:0]    code [3];
    logic          wbe;
`ifdef HZ_WB_FWD_EN
    wbe = wb_wb_en;
`else
    wbe = 1'b0;
`endif
    pa   = '{ex_dst_addr, mem_dst_addr, wb_dst_addr};
    pv   = '{ex_wb_en && !ex_mem_read, mem_wb_en, wbe};
    code = '{2'b10, 2'b01, 2'b11};
    if (!v) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (pv[k] && pa[k] == a) return code[k];
    return 2'b00;
  endfunction

  function automatic logic ref_lu();
    for (int k = 0; k < NS; k++)
      if (id_src_valid[k] && ex_mem_read && ex_wb_en &&
          id_src_addr[k*AW +: AW] == ex_dst_addr)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_in();
    id_src_addr  = '0;
    id_src_valid = '0;
    ex_dst_addr  = '0;
    mem_dst_addr = '0;
    wb_dst_addr  = '0;
    ex_wb_en     = 1'b0;
    mem_wb_en    = 1'b0;
    wb_wb_en     = 1'b0;
    ex_mem_read  = 1'b0;
    br_taken     = 1'b0;
    id_store_req = 1'b0;
    id_out_req   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    rst          = 1'b0;
    ex_wb_en     = 1'b1;
    ex_dst_addr  = 2'd1;
    id_src_addr  = {2'd1, 2'd1};
    id_src_valid = 2'b11;
    @(negedge clk);
    checks++;
    if ({pc_en, if_en, id_stall, out_en_master, br_clr} !== 5'b00001) begin
      fails++;
      $display("FAIL reset_ctl got=%b exp=00001",
               {pc_en, if_en, id_stall, out_en_master, br_clr});
    end
    checks++;
    if (fwd_sel !== 4'b0000) begin
      fails++;
      $display("FAIL reset_fwd got=%b exp=0000", fwd_sel);
    end
    step();
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pc_en, if_en, id_stall, out_en_master, br_clr} !== 5'b11000) begin
      fails++;
      $display("FAIL idle_ctl got=%b exp=11000",
               {pc_en, if_en, id_stall, out_en_master, br_clr});
    end
  endtask

  task automatic test_fwd_priority();
    step();
    clear_in();
    ex_wb_en = 1'b1; ex_dst_addr = 2'd2;
    mem_wb_en = 1'b1; mem_dst_addr = 2'd2;
    id_src_addr[1:0] = 2'd2; id_src_valid[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (fwd_sel[1:0] !== 2'b10) begin
      fails++;
      $display("FAIL fwd_ex_wins got=%b exp=10", fwd_sel[1:0]);
    end
    step();
    ex_wb_en = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_sel[1:0] !== 2'b01) begin
      fails++;
      $display("FAIL fwd_mem got=%b exp=01", fwd_sel[1:0]);
    end
    step();
    mem_wb_en = 1'b0;
    wb_wb_en = 1'b1; wb_dst_addr = 2'd2;
    @(negedge clk);
    checks++;
`ifdef HZ_WB_FWD_EN
    if (fwd_sel[1:0] !== 2'b11) begin
      fails++;
      $display("FAIL fwd_wb got=%b exp=11", fwd_sel[1:0]);
    end
`else
    if (fwd_sel[1:0] !== 2'b00) begin
      fails++;
      $display("FAIL fwd_wb_off got=%b exp=00", fwd_sel[1:0]);
    end
`endif
    step();
    wb_wb_en = 1'b0;
    ex_wb_en = 1'b1;
    id_src_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (fwd_sel !== 4'b0000) begin
      fails++;
      $display("FAIL fwd_invalid got=%b exp=0000", fwd_sel);
    end
  endtask

  task automatic test_load_use();
    step();
    clear_in();
    ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_dst_addr = 2'd1;
    id_src_addr[3:2] = 2'd1; id_src_valid[1] = 1'b1;
    @(negedge clk);
    checks++;
    if ({pc_en, if_en, id_stall} !== 3'b001) begin
      fails++;
      $display("FAIL load_use got=%b exp=001", {pc_en, if_en, id_stall});
    end
    step();
    id_src_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if ({pc_en, if_en, id_stall} !== 3'b110) begin
      fails++;
      $display("FAIL load_use_invalid got=%b exp=110",
               {pc_en, if_en, id_stall});
    end
    step();
    clear_in();
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b1) begin
      fails++;
      $display("FAIL load_use_after got=%b exp=1", pc_en);
    end
  endtask

  task automatic test_out_seq();
    step();
    clear_in();
    id_out_req = 1'b1;
    for (int c = 0; c <= OP + OH; c++) begin
      if (c == 1) id_out_req = 1'b0;
      @(negedge clk);
      checks++;
      if (c < OP + OH) begin
        if ({pc_en, id_stall, out_en_master} !== {2'b01, c >= OP}) begin
          fails++;
          $display("FAIL out_seq c=%0d got=%b exp=01%b", c,
                   {pc_en, id_stall, out_en_master}, c >= OP);
        end
      end else begin
        if ({pc_en, id_stall, out_en_master} !== 3'b100) begin
          fails++;
          $display("FAIL out_seq_end got=%b exp=100",
                   {pc_en, id_stall, out_en_master});
        end
      end
      if (c < OP + OH) step();
    end
  endtask

  task automatic test_store_abort();
    step();
    clear_in();
    id_store_req = 1'b1;
    @(negedge clk);
    checks++;
    if (id_stall !== 1'b1) begin
      fails++;
      $display("FAIL store_req_stall got=%b exp=1", id_stall);
    end
    step();
    br_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ({br_clr, id_stall} !== 2'b11) begin
      fails++;
      $display("FAIL store_abort got=%b exp=11", {br_clr, id_stall});
    end
    step();
    clear_in();
    @(negedge clk);
    checks++;
    if ({pc_en, id_stall, br_clr} !== 3'b100) begin
      fails++;
      $display("FAIL store_abort_next got=%b exp=100",
               {pc_en, id_stall, br_clr});
    end
  endtask

  task automatic test_reset_mid();
    step();
    clear_in();
    id_out_req = 1'b1;
    step();
    id_out_req = 1'b0;
    for (int c = 1; c < OP; c++) step();
    @(negedge clk);
    checks++;
    if (out_en_master !== 1'b1) begin
      fails++;
      $display("FAIL hold_reached got=%b exp=1", out_en_master);
    end
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pc_en, id_stall, out_en_master} !== 3'b100) begin
      fails++;
      $display("FAIL reset_mid got=%b exp=100",
               {pc_en, id_stall, out_en_master});
    end
  endtask

  task automatic test_random_fwd();
    logic [1:0] e;
    for (int n = 0; n < 200; n++) begin
      step();
      clear_in();
      id_src_addr  = NS*AW'($urandom);
      id_src_valid = NS'($urandom);
      ex_dst_addr  = AW'($urandom);
      mem_dst_addr = AW'($urandom);
      wb_dst_addr  = AW'($urandom);
      ex_wb_en     = 1'($urandom);
      mem_wb_en    = 1'($urandom);
      wb_wb_en     = 1'($urandom);
      ex_mem_read  = 1'($urandom_range(0, 3) == 0);
      br_taken     = 1'($urandom_range(0, 3) == 0);
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        e = ref_sel(id_src_addr[i*AW +: AW], id_src_valid[i]);
        checks++;
        if (fwd_sel[i*2 +: 2] !== e) begin
          fails++;
          $display("FAIL rnd_fwd n=%0d op=%0d got=%b exp=%b",
                   n, i, fwd_sel[i*2 +: 2], e);
        end
      end
      checks++;
      if ({pc_en, id_stall, br_clr} !== {!ref_lu(), ref_lu(), br_taken}) begin
        fails++;
        $display("FAIL rnd_lu n=%0d got=%b exp=%b", n,
                 {pc_en, id_stall, br_clr},
                 {!ref_lu(), ref_lu(), br_taken});
      end
    end
  endtask

  // rem = stall cycles left including the current one.
  task automatic test_random_fsm();
    int rem = 0;
    bit outm = 1'b0;
    bit busy;
    bit e_out;
    step();
    clear_in();
    step();
    for (int n = 0; n < 400; n++) begin
      id_out_req   = 1'($urandom_range(0, 7) == 0);
      id_store_req = 1'($urandom_range(0, 5) == 0);
      br_taken     = 1'($urandom_range(0, 9) == 0);
      busy = (rem > 0);
      if (!busy && !br_taken) begin
        if (id_out_req) begin
          rem = OP + OH; outm = 1'b1;
        end else if (id_store_req) begin
          rem = SC; outm = 1'b0;
        end
      end
      e_out = outm && rem > 0 && rem <= OH;
      @(negedge clk);
      checks++;
      if ({pc_en, if_en, id_stall, out_en_master} !==
          {rem == 0, rem == 0, rem > 0, e_out}) begin
        fails++;
        $display("FAIL rnd_fsm n=%0d got=%b exp=%b", n,
                 {pc_en, if_en, id_stall, out_en_master},
                 {rem == 0, rem == 0, rem > 0, e_out});
      end
      if (busy && br_taken) rem = 0;
      else if (rem > 0) rem--;
      step();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_out_seq();
    test_store_abort();
    test_reset_mid();
    test_random_fwd();
    test_random_fsm();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
